// File: rtl/c8_pkg.sv
// Shared types and constants for the c8 down-counter sequencer.
// Holds the FSM state encoding, command opcodes and the default width.
package c8_pkg;

    localparam int C8_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } c8_state_e;

    typedef enum logic [1:0] {
        OP_LOAD_A = 2'd0,
        OP_LOAD_B = 2'd1,
        OP_RUN    = 2'd2,
        OP_CLEAR  = 2'd3
    } c8_op_e;

endpackage

// File: rtl/c8_down_counter.sv
// WIDTH-bit down-counter: sync clear, parallel load, decrement enable, zero flag.
// One cycle from enable to new count; clear beats load, load beats decrement.
module c8_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_ld,
    input  logic [WIDTH-1:0] i_ld_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Decrement is gated by the zero flag so the count can never wrap to all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_ld) begin
            r_count <= i_ld_val;
        end else if (i_dec && !o_zero) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/c8_count_seq.sv
// Sequencer for the c8 down-counter: accepts LOAD/RUN/CLEAR over valid/ready, counts to zero.
// cmd_ready is low in RUN and DONE; the sender holds its command until IDLE/ARMED.
module c8_count_seq
    import c8_pkg::*;
#(
    parameter int WIDTH = C8_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] a_bus,
    input  logic [WIDTH-1:0] b_bus,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             tc
);

    c8_state_e        r_state;
    c8_state_e        w_state_nxt;
    logic             w_fire;
    logic             w_clr;
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_val;
    logic             w_dec;
    logic             w_last;

    c8_down_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clr    (w_clr),
        .i_ld     (w_ld),
        .i_ld_val (w_ld_val),
        .i_dec    (w_dec),
        .o_count  (count),
        .o_zero   (zero)
    );

    assign cmd_ready = (r_state == IDLE) || (r_state == ARMED);
    assign busy      = (r_state == RUN)  || (r_state == DONE);
    assign tc        = (r_state == DONE);
    assign w_fire    = cmd_valid && cmd_ready;
    assign w_last    = (count == WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_ld        = 1'b0;
        w_ld_val    = '0;
        w_dec       = 1'b0;
        case (r_state)
            IDLE, ARMED: begin
                if (w_fire) begin
                    case (c8_op_e'(cmd_op))
                        OP_LOAD_A: begin
                            w_ld        = 1'b1;
                            w_ld_val    = a_bus;
                            w_state_nxt = ARMED;
                        end
                        OP_LOAD_B: begin
                            w_ld        = 1'b1;
                            w_ld_val    = b_bus;
                            w_state_nxt = ARMED;
                        end
                        OP_CLEAR: begin
                            w_clr       = 1'b1;
                            w_state_nxt = IDLE;
                        end
                        OP_RUN: begin
                            w_state_nxt = zero ? DONE : RUN;
                        end
                        default: ;
                    endcase
                end
            end
            // stop wins over the decrement, even on the final step
            RUN: begin
                if (stop) begin
                    w_state_nxt = ARMED;
                end else begin
                    w_dec = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_c8_count_seq.sv
// Directed bench for c8_count_seq; expected per-cycle outputs are queued by the driver
// and checked by an independent negedge monitor.
module tb_c8_count_seq;

    localparam logic [1:0] LDA = 2'd0;
    localparam logic [1:0] LDB = 2'd1;
    localparam logic [1:0] RN  = 2'd2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] a_bus = 8'h00;
    logic [7:0] b_bus = 8'h00;
    logic       stop = 1'b0;
    logic [7:0] count;
    logic       zero;
    logic       busy;
    logic       tc;

    typedef struct {
        string      name;
        logic [7:0] cnt;
        logic       busy;
        logic       tc;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   tc_total = 0;

    c8_count_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .a_bus     (a_bus),
        .b_bus     (b_bus),
        .stop      (stop),
        .count     (count),
        .zero      (zero),
        .busy      (busy),
        .tc        (tc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: compares every queued expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [11:0] act;
            logic [11:0] req;
            mon_e = exp_q.pop_front();
            act = {count, zero, busy, tc, cmd_ready};
            req = {mon_e.cnt, (mon_e.cnt == 8'h00), mon_e.busy, mon_e.tc, mon_e.rdy};
            n_checks++;
            if (act !== req) begin
                n_fail++;
                $display("FAIL %s: got count=%h zero=%b busy=%b tc=%b rdy=%b, want count=%h zero=%b busy=%b tc=%b rdy=%b",
                         mon_e.name, count, zero, busy, tc, cmd_ready,
                         mon_e.cnt, (mon_e.cnt == 8'h00), mon_e.busy, mon_e.tc, mon_e.rdy);
            end
        end
        if (tc === 1'b1) tc_total++;
    end

    task automatic tick(input logic v, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic s, input logic r);
        cmd_valid = v;
        cmd_op    = op;
        a_bus     = a;
        b_bus     = b;
        stop      = s;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_tick();
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic [7:0] cnt,
                              input logic bsy, input logic t, input logic rdy);
        exp_t e;
        e.name = name;
        e.cnt  = cnt;
        e.busy = bsy;
        e.tc   = t;
        e.rdy  = rdy;
        exp_q.push_back(e);
    endtask

    initial begin
        // Reset for two cycles, then idle
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b1);
        expect_out("reset", 8'h00, 1'b0, 1'b0, 1'b1);
        idle_tick();
        expect_out("idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // LOAD_A 3 then RUN: 3,2,1,0 with tc three edges after RUN
        tick(1'b1, LDA, 8'h03, 8'h00, 1'b0, 1'b0);
        expect_out("load_a3", 8'h03, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run3_acc", 8'h03, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run3_c2", 8'h02, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run3_c1", 8'h01, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run3_done", 8'h00, 1'b1, 1'b1, 1'b0);
        idle_tick(); expect_out("run3_idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // LOAD_B 5, RUN, stop for two cycles at count 3, then resume
        tick(1'b1, LDB, 8'h00, 8'h05, 1'b0, 1'b0);
        expect_out("load_b5", 8'h05, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run5_acc", 8'h05, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run5_c4", 8'h04, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run5_c3", 8'h03, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_out("stop1_armed", 8'h03, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_out("stop2_hold", 8'h03, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("resume_acc", 8'h03, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("resume_c2", 8'h02, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("resume_c1", 8'h01, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("resume_done", 8'h00, 1'b1, 1'b1, 1'b0);
        idle_tick(); expect_out("resume_idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // stop beats the final decrement at count 1
        tick(1'b1, LDA, 8'h01, 8'h00, 1'b0, 1'b0);
        expect_out("load_a1", 8'h01, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run1_acc", 8'h01, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0);
        expect_out("stop_at1", 8'h01, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run1_again", 8'h01, 1'b1, 1'b0, 1'b0);
        idle_tick(); expect_out("run1_done", 8'h00, 1'b1, 1'b1, 1'b0);
        idle_tick(); expect_out("run1_idle", 8'h00, 1'b0, 1'b0, 1'b1);

        // RUN with count 0: straight to DONE, no wrap
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run0_done", 8'h00, 1'b1, 1'b1, 1'b0);
        idle_tick(); expect_out("run0_idle", 8'h00, 1'b0, 1'b0, 1'b1);
        idle_tick(); expect_out("run0_nowrap", 8'h00, 1'b0, 1'b0, 1'b1);

        // LOAD_A FF, RUN, reset at F0 (with competing cmd and stop)
        tick(1'b1, LDA, 8'hFF, 8'h00, 1'b0, 1'b0);
        expect_out("load_aff", 8'hFF, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("runff_acc", 8'hFF, 1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 15; j++) begin
            idle_tick();
            expect_out("runff_dec", 8'(8'hFF - j), 1'b1, 1'b0, 1'b0);
        end
        tick(1'b1, LDA, 8'h55, 8'h00, 1'b1, 1'b1);
        expect_out("abort_rst", 8'h00, 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            idle_tick();
            expect_out("abort_no_tc", 8'h00, 1'b0, 1'b0, 1'b1);
        end

        // LOAD_A held during RUN is not accepted until IDLE
        tick(1'b1, LDA, 8'h04, 8'h00, 1'b0, 1'b0);
        expect_out("load_a4", 8'h04, 1'b0, 1'b0, 1'b1);
        tick(1'b1, RN, 8'h00, 8'h00, 1'b0, 1'b0);
        expect_out("run4_acc", 8'h04, 1'b1, 1'b0, 1'b0);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_c3", 8'h03, 1'b1, 1'b0, 1'b0);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_c2", 8'h02, 1'b1, 1'b0, 1'b0);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_c1", 8'h01, 1'b1, 1'b0, 1'b0);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_done", 8'h00, 1'b1, 1'b1, 1'b0);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_idle", 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b1, LDA, 8'h77, 8'h00, 1'b0, 1'b0);
        expect_out("held_loaded", 8'h77, 1'b0, 1'b0, 1'b1);
        idle_tick();
        expect_out("held_armed", 8'h77, 1'b0, 1'b0, 1'b1);

        idle_tick();
        idle_tick();

        n_checks++;
        if (tc_total != 5) begin
            n_fail++;
            $display("FAIL tc_total: got %0d pulses, want 5", tc_total);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
